// File: rtl/lf_adder_pkg.sv
// Shared definitions for the Ling/prefix adder sum stage.
//   LF_WIDTH_DEFAULT : default operand/sum width (legal: 8, 16, 32, 64)
//   fifo_state_e     : occupancy of the 2-entry result FIFO in lf_sum_stage
package lf_adder_pkg;

  localparam int LF_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/lf_sum_core.sv
// Combinational sum/carry core of the adder. Takes the prefix network's
// group generate/propagate (bit i spans bits i..0) and forms final carries,
// the sum and the carry out.
//   half_i  : per-bit half-sum a^b
//   gen_i   : group generate, bit i covers i..0
//   prop_i  : group propagate, bit i covers i..0
//   cin_i   : carry into bit 0
//   sum_o   : sum
//   cout_o  : carry out of the MSB
//   ovf_o   : signed overflow (only when ADDER_OVF_EN is defined)
// Build option: ADDER_OVF_EN adds the ovf_o output.
module lf_sum_core
  import lf_adder_pkg::*;
#(
  parameter int WIDTH = LF_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] half_i,
  input  logic [WIDTH-1:0] gen_i,
  input  logic [WIDTH-1:0] prop_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef ADDER_OVF_EN
  output logic             cout_o,
  output logic             ovf_o
`else
  output logic             cout_o
`endif
);

  logic [WIDTH-1:0] carry;

  // Carry into bit i is the group term of bits i-1..0 with cin folded in.
  assign carry  = {gen_i[WIDTH-2:0] | (prop_i[WIDTH-2:0] & {(WIDTH-1){cin_i}}), cin_i};
  assign sum_o  = half_i ^ carry;
  assign cout_o = gen_i[WIDTH-1] | (prop_i[WIDTH-1] & cin_i);

`ifdef ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_o = carry[WIDTH-1] ^ cout_o;
`endif

endmodule

// File: rtl/lf_sum_stage.sv
// Final sum stage of the adder with a 2-entry output FIFO and valid/ready
// handshakes on both sides. Results appear one cycle after acceptance when
// the FIFO is empty; in_ready is registered and drops only when full.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   p_in, G_in, P_in    : half-sum, group generate, group propagate
//   cin                 : carry into bit 0
//   out_valid/out_ready : output handshake
//   sum, cout           : registered result at FIFO head
//   ovf                 : registered signed overflow (ADDER_OVF_EN only)
// Build option: ADDER_OVF_EN adds the ovf port and per-entry ovf storage.
module lf_sum_stage
  import lf_adder_pkg::*;
#(
  parameter int WIDTH = LF_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] G_in,
  input  logic [WIDTH-1:0] P_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  fifo_state_e      state_q, state_d;
  logic             in_ready_q;
  logic             push, pop;
  logic             head_ld_new, head_ld_tail, tail_ld;

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic [WIDTH-1:0] head_sum_q, tail_sum_q;
  logic             head_cout_q, tail_cout_q;
`ifdef ADDER_OVF_EN
  logic             core_ovf;
  logic             head_ovf_q, tail_ovf_q;
`endif

  lf_sum_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .half_i (p_in),
    .gen_i  (G_in),
    .prop_i (P_in),
    .cin_i  (cin),
    .sum_o  (core_sum),
`ifdef ADDER_OVF_EN
    .cout_o (core_cout),
    .ovf_o  (core_ovf)
`else
    .cout_o (core_cout)
`endif
  );

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  // State register. in_ready tracks the next state so it is a flop output,
  // and stays low during reset until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Output / datapath control. Head is always the oldest entry; a push
  // lands in the head when it is (or becomes) free, else in the tail.
  always_comb begin
    out_valid    = (state_q != EMPTY);
    head_ld_new  = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld      = 1'b0;
    case (state_q)
      EMPTY: head_ld_new = push;
      ONE: begin
        head_ld_new = push & pop;
        tail_ld     = push & ~pop;
      end
      FULL:    head_ld_tail = pop;
      default: ;
    endcase
  end

  // Result storage is reset so outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_sum_q  <= '0;
      head_cout_q <= 1'b0;
      tail_sum_q  <= '0;
      tail_cout_q <= 1'b0;
`ifdef ADDER_OVF_EN
      head_ovf_q  <= 1'b0;
      tail_ovf_q  <= 1'b0;
`endif
    end else begin
      if (head_ld_new) begin
        head_sum_q  <= core_sum;
        head_cout_q <= core_cout;
`ifdef ADDER_OVF_EN
        head_ovf_q  <= core_ovf;
`endif
      end else if (head_ld_tail) begin
        head_sum_q  <= tail_sum_q;
        head_cout_q <= tail_cout_q;
`ifdef ADDER_OVF_EN
        head_ovf_q  <= tail_ovf_q;
`endif
      end
      if (tail_ld) begin
        tail_sum_q  <= core_sum;
        tail_cout_q <= core_cout;
`ifdef ADDER_OVF_EN
        tail_ovf_q  <= core_ovf;
`endif
      end
    end
  end

  assign in_ready = in_ready_q;
  assign sum      = head_sum_q;
  assign cout     = head_cout_q;
`ifdef ADDER_OVF_EN
  assign ovf      = head_ovf_q;
`endif

endmodule

// File: tb/tb_lf_sum_stage.sv
// Testbench for lf_sum_stage (WIDTH=64). Operands a, b are turned into the
// p/G/P bundle the prefix network would deliver; expected results come from
// plain 65-bit addition. Build option: ADDER_OVF_EN enables ovf checking.
module tb_lf_sum_stage;

  localparam int W = 64;
`ifdef ADDER_OVF_EN
  localparam logic [65:0] CMP_MASK = {66{1'b1}};
`else
  localparam logic [65:0] CMP_MASK = {1'b0, {65{1'b1}}};
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  p_in;
  logic [W-1:0]  G_in;
  logic [W-1:0]  P_in;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic [65:0]   got;
`ifdef ADDER_OVF_EN
  logic          ovf;
  assign got = {ovf, cout, sum};
`else
  assign got = {1'b0, cout, sum};
`endif

  int            n_vec;
  int            n_err;
  logic [65:0]   exp_q[$];

  lf_sum_stage #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .G_in      (G_in),
    .P_in      (P_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef ADDER_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} of a + b + ci.
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci);
    logic [64:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    v = (a[63] == b[63]) && (s[63] != a[63]);
    return {v, s};
  endfunction

  // Produce the bundle a prefix network would hand to this stage.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [63:0] pp, gg, grp_g, grp_p;
    logic        gr, pr;
    pp = a ^ b;
    gg = a & b;
    gr = 1'b0;
    pr = 1'b1;
    for (int i = 0; i < 64; i++) begin
      gr       = gg[i] | (pp[i] & gr);
      pr       = pr & pp[i];
      grp_g[i] = gr;
      grp_p[i] = pr;
    end
    p_in = pp;
    G_in = grp_g;
    P_in = grp_p;
    cin  = ci;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
    end
    n_vec++;
    if (got !== 66'd0) begin
      n_err++;
      $display("FAIL reset_data: got=%h want 0", got);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_edge: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [63:0] ta[3];
    logic [63:0] tb_v[3];
    logic        tc[3];
    logic [65:0] te[3];
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb_v[0] = 64'd1; tc[0] = 1'b0;
    te[0] = {1'b0, 1'b1, 64'h0};
    ta[1] = 64'h7FFF_FFFF_FFFF_FFFF; tb_v[1] = 64'd1; tc[1] = 1'b0;
    te[1] = {1'b1, 1'b0, 64'h8000_0000_0000_0000};
    ta[2] = 64'd0;                   tb_v[2] = 64'd0; tc[2] = 1'b1;
    te[2] = {1'b0, 1'b0, 64'd1};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(ta[k], tb_v[k], tc[k]);
      in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_pre: in_ready=%b out_valid=%b want 1 0", k, in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_latency: out_valid=%b want 1", k, out_valid);
      end
      n_vec++;
      if (got !== (te[k] & CMP_MASK)) begin
        n_err++;
        $display("FAIL dir%0d_result: got=%h want %h", k, got, te[k] & CMP_MASK);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_pop: out_valid=%b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] va[3];
    logic [63:0] vb[3];
    logic        vc[3];
    logic [65:0] ve[3];
    int          idx;
    logic        acc;
    for (int k = 0; k < 3; k++) begin
      va[k] = {$urandom, $urandom};
      vb[k] = {$urandom, $urandom};
      vc[k] = 1'($urandom_range(0, 1));
      ve[k] = ref_add(va[k], vb[k], vc[k]);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      if (idx < 3) begin
        drive(va[idx], vb[idx], vc[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== (idx < 2)) begin
        n_err++;
        $display("FAIL bp_ready c%0d: in_ready=%b want %b", cyc, in_ready, idx < 2);
      end
      n_vec++;
      if (cyc == 0) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
        end
      end else if (out_valid !== 1'b1 || got !== (ve[0] & CMP_MASK)) begin
        n_err++;
        $display("FAIL bp_hold c%0d: out_valid=%b got=%h want 1 %h", cyc, out_valid, got,
                 ve[0] & CMP_MASK);
      end
      acc = in_valid & in_ready;
      if (acc) idx++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || got !== (ve[k] & CMP_MASK)) begin
        n_err++;
        $display("FAIL bp_order%0d: out_valid=%b got=%h want 1 %h", k, out_valid, got,
                 ve[k] & CMP_MASK);
      end
      if (k == 0) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_full_ready: in_ready=%b want 0", in_ready);
        end
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    logic        c;
    logic [65:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      drive(a, b, c);
      in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready%0d: in_ready=%b want 1", i, in_ready);
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || got !== (e & CMP_MASK)) begin
          n_err++;
          $display("FAIL b2b_result%0d: out_valid=%b got=%h want 1 %h", i, out_valid, got,
                   e & CMP_MASK);
        end
      end
      exp_q.push_back(ref_add(a, b, c));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || got !== (e & CMP_MASK)) begin
      n_err++;
      $display("FAIL b2b_last: out_valid=%b got=%h want 1 %h", out_valid, got, e & CMP_MASK);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_full;
    logic [63:0] a, b;
    logic        c;
    logic [65:0] e;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rf_full: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== 66'd0) begin
      n_err++;
      $display("FAIL rf_async: out_valid=%b in_ready=%b got=%h want 0 0 0", out_valid, in_ready,
               got);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rf_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = 1'($urandom_range(0, 1));
    e = ref_add(a, b, c);
    @(posedge clk); #1;
    drive(a, b, c);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || got !== (e & CMP_MASK)) begin
      n_err++;
      $display("FAIL rf_next: out_valid=%b got=%h want 1 %h", out_valid, got, e & CMP_MASK);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rf_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    p_in      = '0;
    G_in      = '0;
    P_in      = '0;
    cin       = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lf_sum_stage.md
LF_SUM_STAGE -- requirements
Module: lf_sum_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/sum width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the input bundle is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the stage accepts the bundle this cycle.
REQ-006 SHALL have port p_in, input, WIDTH, per-bit half-sum a^b.
REQ-007 SHALL have port G_in, input, WIDTH, carry-network group generate (bit i spans bits i..0).
REQ-008 SHALL have port P_in, input, WIDTH, carry-network group propagate (bit i spans bits i..0).
REQ-009 SHALL have port cin, input, 1, carry into bit 0.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH, the registered sum.
REQ-013 SHALL have port cout, output, 1, the registered carry out.
REQ-014 SHALL have port ovf, output, 1, the signed overflow flag; present only when ADDER_OVF_EN is defined.

Function
REQ-015 SHALL compute carries as c[0]=cin and c[i]=G_in[i-1] | (P_in[i-1] & cin) for i>=1.
REQ-016 SHALL compute sum[i]=p_in[i]^c[i], and cout=G_in[WIDTH-1] | (P_in[WIDTH-1] & cin).
REQ-017 SHALL treat a transfer as in_valid & in_ready on input, and out_valid & out_ready on output.
REQ-018 SHALL buffer results in a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-019 SHALL make in_ready a registered signal equal to (state != FULL).
REQ-020 SHALL have a latency of 1 cycle: a bundle accepted in cycle N appears on out_valid in cycle N+1 when the FIFO was EMPTY.
REQ-021 SHALL apply these transitions:
- EMPTY + push -> ONE
- ONE + push without pop -> FULL
- ONE + pop without push -> EMPTY
- ONE + push and pop -> ONE, with the new entry at the head next cycle
- FULL + pop -> ONE; FULL never accepts a push.
REQ-022 SHALL hold sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-023 SHALL deliver results strictly in acceptance order, with no drops and no duplicates.
REQ-024 SHALL present out_valid independently of out_ready, with no combinational ready-to-valid path.
REQ-025 SHALL ignore in_valid, and leave the data inputs don't-care, when in_ready=0.

Reset
REQ-026 SHALL on rst_n=0 immediately force state=EMPTY, out_valid=0, in_ready=0, sum=0, cout=0 and ovf=0.
REQ-027 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.
REQ-028 SHALL discard any buffered entries when reset is asserted mid-operation, with no result emitted afterwards.

Configuration
REQ-029 SHALL, with ADDER_OVF_EN defined, output ovf = c[WIDTH-1] ^ cout, stored per FIFO entry.
REQ-030 SHALL, without ADDER_OVF_EN, have no ovf port and no ovf storage.

Structure
REQ-031 SHALL take the FIFO state enum (EMPTY/ONE/FULL) and the default WIDTH constant from shared package lf_adder_pkg.
REQ-032 SHALL place the carry/sum equations (REQ-015, REQ-016, REQ-029) in combinational sub-module lf_sum_core, with the FIFO in lf_sum_stage.

Verification
REQ-033 SHALL cover: WIDTH=64, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 (p, G, P from the prefix network) -> next cycle sum=0, cout=1; with ADDER_OVF_EN, ovf=0.
REQ-034 SHALL cover: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0; with ADDER_OVF_EN, ovf=1.
REQ-035 SHALL cover: a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-036 SHALL cover: out_ready=0 for 5 cycles while 3 bundles are offered -> in_ready falls after 2 pushes; out_valid and sum stay stable; releasing out_ready yields results in order with 1 cycle each.
REQ-037 SHALL cover: out_ready=1 with in_valid=1 every cycle for 100 random bundles -> in_ready stays 1, throughput is 1 per cycle, and all sums match a reference model.
REQ-038 SHALL cover: rst_n asserted while FULL -> out_valid=0 immediately; after release the next output is the next new bundle.
